// File: rtl/npc_stage_ctrl.sv
// npc_stage_ctrl
// Multi-cycle sequencer for the NPC core. One instruction at a time is walked
// through fetch, decode, dispatch, execute, memory and writeback. The FSM pulses
// the per-unit enables and runs the instruction/data memory handshakes. It stops
// in HALT on EBREAK, on an illegal type, or when a memory wait runs out.
// MEM_TIMEOUT must lie in 1..255 so that it fits the 8-bit wait counter.

module npc_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        IFU_en,
  output logic        IDU_en,
  input  logic [6:0]  tp,
  output logic        EXU_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        WBU_en,
  output logic        pc_en,
  output logic        halted,
  output logic [1:0]  trap,
  output logic [31:0] instret
);

  // Decoder type codes
  localparam logic [6:0] TP_I_ADDI = 7'h00;
  localparam logic [6:0] TP_I_LW   = 7'h01;
  localparam logic [6:0] TP_S_SB   = 7'h02;
  localparam logic [6:0] TP_S_SW   = 7'h03;
  localparam logic [6:0] TP_S_SH   = 7'h06;
  localparam logic [6:0] TP_EBREAK = 7'h7F;

  // Halt causes
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_EBREAK  = 2'b01;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b10;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b11;

  // The wait counter holds the number of ack-less cycles already spent in the
  // current wait. The cycle on which it shows WAIT_LAST is the final cycle in
  // which an ack is still accepted; if no ack arrives then, we trap.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_DISPATCH = 3'd3,
    S_EXEC     = 3'd4,
    S_MEM      = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    C_ALU   = 2'd0,
    C_LOAD  = 2'd1,
    C_STORE = 2'd2,
    C_NONE  = 2'd3
  } cls_e;

  // Map a decoder type onto the execution class; C_NONE means "not executable".
  function automatic cls_e classify(input logic [6:0] t);
    cls_e c;
    case (t)
      TP_I_ADDI: c = C_ALU;
      TP_I_LW:   c = C_LOAD;
      TP_S_SB,
      TP_S_SW,
      TP_S_SH:   c = C_STORE;
      default:   c = C_NONE;
    endcase
    return c;
  endfunction

  state_e      state_q,   state_d;
  cls_e        class_q,   class_d;
  logic [7:0]  wait_q,    wait_d;
  logic [1:0]  trap_q,    trap_d;
  logic [31:0] instret_q, instret_d;

  cls_e        tp_class_s;
  logic        wait_last_s;

  assign tp_class_s  = classify(tp);
  assign wait_last_s = (wait_q >= WAIT_LAST);

  // Next-state, class latch, wait counter, trap cause and retire counter
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wait_d    = wait_q;
    trap_d    = trap_q;
    instret_d = instret_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        // An ack in the last allowed cycle takes priority over the timeout.
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_last_s) begin
          state_d = S_HALT;
          trap_d  = TRAP_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        state_d = S_DISPATCH;
      end

      S_DISPATCH: begin
        // tp is valid here: the decoder registered it on the IDU_en cycle.
        class_d = tp_class_s;
        if (tp_class_s != C_NONE) begin
          state_d = S_EXEC;
        end else if (tp == TP_EBREAK) begin
          state_d = S_HALT;
          trap_d  = TRAP_EBREAK;
        end else begin
          state_d = S_HALT;
          trap_d  = TRAP_ILLEGAL;
        end
      end

      S_EXEC: begin
        if (class_q == C_ALU) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
          wait_d  = 8'd0;
        end
      end

      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (wait_last_s) begin
          state_d = S_HALT;
          trap_d  = TRAP_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB: begin
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
        wait_d    = 8'd0;
      end

      S_HALT: begin
        // Absorbing: start and acks are ignored until reset.
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
        trap_d  = TRAP_ILLEGAL;
      end
    endcase
  end

  // Moore decode of the unit enables and requests from the current state
  always_comb begin
    imem_req = 1'b0;
    IFU_en   = 1'b0;
    IDU_en   = 1'b0;
    EXU_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    WBU_en   = 1'b0;
    pc_en    = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        IFU_en   = imem_ack;
      end
      S_DECODE: begin
        IDU_en = 1'b1;
      end
      S_EXEC: begin
        EXU_en = 1'b1;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_q == C_STORE);
      end
      S_WB: begin
        pc_en  = 1'b1;
        WBU_en = (class_q == C_ALU) || (class_q == C_LOAD);
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  assign trap    = trap_q;
  assign instret = instret_q;

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      class_q   <= C_ALU;
      wait_q    <= 8'd0;
      trap_q    <= TRAP_NONE;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_npc_stage_ctrl.sv
// tb_npc_stage_ctrl
// Programs (type, fetch delay, data delay) are turned into an expected
// cycle-by-cycle output trace from the controller's stage rules; the bench
// replays the matching stimulus and compares every cycle.

module tb_npc_stage_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic        imem_ack;
  logic        IFU_en;
  logic        IDU_en;
  logic [6:0]  tp;
  logic        EXU_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        WBU_en;
  logic        pc_en;
  logic        halted;
  logic [1:0]  trap;
  logic [31:0] instret;

  always #5 clk = ~clk;

  npc_stage_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .IFU_en   (IFU_en),
    .IDU_en   (IDU_en),
    .tp       (tp),
    .EXU_en   (EXU_en),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .dmem_ack (dmem_ack),
    .WBU_en   (WBU_en),
    .pc_en    (pc_en),
    .halted   (halted),
    .trap     (trap),
    .instret  (instret)
  );

  int total = 0;
  int bad   = 0;

  // program: type, cycles before imem_ack, cycles before dmem_ack
  logic [6:0]  p_tp[$];
  int          p_id[$];
  int          p_dd[$];
  // trace: stimulus {start, imem_ack, dmem_ack, tp} and expected outputs
  logic [9:0]  st_q[$];
  logic [42:0] ex_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rtp();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic bit is_alu(input logic [6:0] t);
    return t == 7'h00;
  endfunction
  function automatic bit is_ld(input logic [6:0] t);
    return t == 7'h01;
  endfunction
  function automatic bit is_st(input logic [6:0] t);
    return (t == 7'h02) || (t == 7'h03) || (t == 7'h06);
  endfunction

  // {instret, trap, halted, pc_en, WBU_en, dmem_we, dmem_req, EXU_en, IDU_en, IFU_en, imem_req}
  function automatic logic [42:0] mk(input logic [31:0] ir, input logic [1:0] tr, input logic hl,
                                     input logic pc, input logic wbu, input logic we, input logic dreq,
                                     input logic exu, input logic idu, input logic ifu, input logic ireq);
    return {ir, tr, hl, pc, wbu, we, dreq, exu, idu, ifu, ireq};
  endfunction

  function automatic logic [42:0] outv();
    return {instret, trap, halted, pc_en, WBU_en, dmem_we, dmem_req, EXU_en, IDU_en, IFU_en, imem_req};
  endfunction

  task automatic add_prog(input logic [6:0] t, input int id, input int dd);
    p_tp.push_back(t);
    p_id.push_back(id);
    p_dd.push_back(dd);
  endtask

  task automatic push(input logic [9:0] s, input logic [42:0] e);
    st_q.push_back(s);
    ex_q.push_back(e);
  endtask

  // Expand the program into per-cycle stimulus and expected outputs
  task automatic build();
    logic [31:0] cnt;
    logic [1:0]  tr;
    bit          done;
    bit          acked;
    st_q.delete();
    ex_q.delete();
    cnt  = 32'd0;
    tr   = 2'b00;
    done = 0;
    push({1'b0, rb(), rb(), rtp()}, 43'd0);
    push({1'b0, rb(), rb(), rtp()}, 43'd0);
    push({1'b1, rb(), rb(), rtp()}, 43'd0);
    for (int k = 0; k < p_tp.size() && !done; k++) begin
      logic [6:0] t;
      t = p_tp[k];
      acked = 0;
      for (int j = 0; j < T; j++) begin
        if (j == p_id[k]) begin
          push({rb(), 1'b1, rb(), rtp()}, mk(cnt, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1));
          acked = 1;
          break;
        end
        push({rb(), 1'b0, rb(), rtp()}, mk(cnt, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      if (!acked) begin
        tr = 2'b11;
        done = 1;
        break;
      end
      push({rb(), rb(), rb(), rtp()}, mk(cnt, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      push({rb(), rb(), rb(), t}, mk(cnt, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (!(is_alu(t) || is_ld(t) || is_st(t))) begin
        tr = (t == 7'h7F) ? 2'b01 : 2'b10;
        done = 1;
        break;
      end
      push({rb(), rb(), rb(), rtp()}, mk(cnt, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      if (!is_alu(t)) begin
        acked = 0;
        for (int j = 0; j < T; j++) begin
          if (j == p_dd[k]) begin
            push({rb(), rb(), 1'b1, rtp()}, mk(cnt, 2'b00, 0, 0, 0, is_st(t), 1, 0, 0, 0, 0));
            acked = 1;
            break;
          end
          push({rb(), rb(), 1'b0, rtp()}, mk(cnt, 2'b00, 0, 0, 0, is_st(t), 1, 0, 0, 0, 0));
        end
        if (!acked) begin
          tr = 2'b11;
          done = 1;
          break;
        end
      end
      push({rb(), rb(), rb(), rtp()}, mk(cnt, 2'b00, 0, 1, !is_st(t), 0, 0, 0, 0, 0, 0));
      cnt = cnt + 32'd1;
    end
    if (done) begin
      for (int h = 0; h < 5; h++)
        push({rb(), rb(), rb(), rtp()}, mk(cnt, tr, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // Reset, replay the trace (optionally cut short by a mid-run reset)
  task automatic run(input string name, input int abort_at);
    build();
    rst = 1'b1;
    {start, imem_ack, dmem_ack, tp} = {rb(), rb(), rb(), rtp()};
    @(posedge clk); #1;
    check_val({name, ":reset"}, outv(), 43'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < st_q.size(); i++) begin
      if (i == abort_at) break;
      {start, imem_ack, dmem_ack, tp} = st_q[i];
      @(negedge clk);
      check_val($sformatf("%s:cyc%0d", name, i), outv(), ex_q[i]);
      @(posedge clk); #1;
    end
    if (abort_at >= 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      check_val({name, ":midrst"}, outv(), 43'd0);
      rst = 1'b0;
    end
  endtask

  task automatic clear_prog();
    p_tp.delete();
    p_id.delete();
    p_dd.delete();
  endtask

  task automatic gen_random();
    int n;
    logic [6:0] legal[5];
    legal[0] = 7'h00; legal[1] = 7'h01; legal[2] = 7'h02; legal[3] = 7'h03; legal[4] = 7'h06;
    clear_prog();
    n = $urandom_range(1, 8);
    for (int k = 0; k < n; k++) begin
      int r;
      int id;
      int dd;
      logic [6:0] t;
      r = $urandom_range(0, 19);
      if (r < 18) begin
        t = legal[$urandom_range(0, 4)];
      end else if (r == 18) begin
        t = 7'h7F;
      end else begin
        do t = rtp(); while (is_alu(t) || is_ld(t) || is_st(t) || t == 7'h7F);
      end
      id = ($urandom_range(0, 15) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, T - 1);
      dd = ($urandom_range(0, 15) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, T - 1);
      add_prog(t, id, dd);
    end
    add_prog(7'h7F, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    tp = 7'h00;

    clear_prog();
    add_prog(7'h00, 0, 0);
    add_prog(7'h7F, 0, 0);
    run("addi", -1);

    clear_prog();
    add_prog(7'h01, 0, 3);
    add_prog(7'h03, 0, 0);
    add_prog(7'h06, 1, 2);
    add_prog(7'h7F, 0, 0);
    run("lw_sw_sh_ebreak", -1);

    clear_prog();
    add_prog(7'h10, 0, 0);
    run("illegal", -1);

    clear_prog();
    add_prog(7'h00, T, 0);
    run("fetch_timeout", -1);

    clear_prog();
    add_prog(7'h00, T - 1, 0);
    add_prog(7'h02, 0, T);
    run("ack_at_limit_then_mem_timeout", -1);

    clear_prog();
    add_prog(7'h01, 0, T - 1);
    add_prog(7'h7F, 0, 0);
    run("mem_ack_at_limit", -1);

    for (int r = 0; r < 40; r++) begin
      int ab;
      gen_random();
      build();
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(3, st_q.size() - 1) : -1;
      run($sformatf("rnd%0d", r), ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_stage_ctrl.md
# npc_stage_ctrl

Multi-cycle sequencing controller for the NPC core. It steps one instruction at a time through fetch, decode, execute, memory and writeback by pulsing the per-unit enables (`IFU_en`, `IDU_en`, `EXU_en`, `WBU_en`) and running the instruction- and data-memory request/acknowledge handshakes. It also dispatches on the registered instruction type from the decoder, halts on `EBREAK` or an illegal instruction, and guards each memory wait with a timeout.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of cycles to wait for `imem_ack` or `dmem_ack` before trapping.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  leave IDLE and begin fetching; level-sampled.
- `imem_req`  out  1  instruction fetch request; held until acknowledged.
- `imem_ack`  in  1  fetch data valid this cycle.
- `IFU_en`  out  1  instruction register capture strobe; equals `imem_ack` while in FETCH.
- `IDU_en`  out  1  decoder enable; asserted for one cycle.
- `tp`  in  7  decoded type from the registered decoder; valid the cycle after `IDU_en`.
- `EXU_en`  out  1  execute enable; asserted for one cycle.
- `dmem_req`  out  1  data memory request; held until acknowledged.
- `dmem_we`  out  1  write request qualifier; 1 for stores.
- `dmem_ack`  in  1  data access complete.
- `WBU_en`  out  1  register-file write enable; asserted for one cycle.
- `pc_en`  out  1  PC update strobe; asserted for one cycle per retired instruction.
- `halted`  out  1  core stopped.
- `trap`  out  2  halt cause: 00 none, 01 ebreak, 10 illegal, 11 memory timeout.
- `instret`  out  32  count of retired instructions.

## Operation
- Type codes come from `macro.v`: `I_ADDI`=7'h00, `I_LW`=7'h01, `S_SB`=7'h02, `S_SW`=7'h03, `S_SH`=7'h06, `EBREAK`=7'h7F. Every other value, including `NONE`, is illegal.
- States: IDLE, FETCH, DECODE, DISPATCH, EXEC, MEM, WB, HALT.
- IDLE: all outputs 0. Go to FETCH when `start`=1.
- FETCH: `imem_req`=1. On `imem_ack` go to DECODE.
- DECODE: `IDU_en`=1. Always go to DISPATCH.
- DISPATCH: read `tp` and latch a 2-bit class (ALU, LOAD, STORE).
  - ALU/LOAD/STORE types go to EXEC.
  - `EBREAK` goes to HALT with `trap`=01.
  - Illegal types go to HALT with `trap`=10.
- EXEC: `EXU_en`=1. Class ALU goes to WB; LOAD and STORE go to MEM.
- MEM: `dmem_req`=1; `dmem_we`=1 for STORE. On `dmem_ack` go to WB.
- WB: `pc_en`=1; `WBU_en`=1 only for ALU and LOAD. `instret` increments by 1, wrapping at 2^32. Then go to FETCH.
- HALT: `halted`=1 and `trap` held. Absorbing; only `rst` exits. `start` is ignored.
- Wait counter (8 bits, sized to hold `MEM_TIMEOUT`):
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle without an ack.
  - If it reaches `MEM_TIMEOUT` with no ack, go to HALT with `trap`=11.
  - An ack arriving in the same cycle the counter reaches the limit wins; no trap.
- Acks arriving outside FETCH/MEM are ignored.

## Timing
- Reset: state IDLE, `trap`=00, `instret`=0, wait counter 0, and every enable/request output 0. Reset mid-instruction discards the instruction with no retire.
- Enables and requests are Moore outputs decoded from state, except `IFU_en` (= FETCH & `imem_ack`).
- Latency with zero-wait acks:
  - ALU instruction: 5 cycles (FETCH, DECODE, DISPATCH, EXEC, WB).
  - LOAD or STORE: 6 cycles.
- Each wait cycle on a memory ack adds 1 cycle.
- `halted` rises the cycle after DISPATCH sees `EBREAK`, or after a timeout is detected.
- `imem_req` and `dmem_req` never overlap.
- `pc_en` fires exactly once per retired instruction. No retire for `EBREAK`, illegal, or timeout.

## Test plan
- Reset, then `start`=1, `imem_ack` tied 1, `tp`=`I_ADDI` -> `IFU_en`, `IDU_en`, `EXU_en`, `WBU_en`+`pc_en` in cycles 1–5 after start. `instret`=1 after the first WB.
- `tp`=`I_LW`, `dmem_ack` 3 cycles late -> `dmem_req` high 4 cycles with `dmem_we`=0, then `WBU_en`=1. Total 9 cycles.
- `tp`=`S_SW`, then `tp`=`S_SH` -> `dmem_we`=1 during MEM, `WBU_en`=0, `pc_en`=1. `instret` advances by 2.
- Third instruction `tp`=`EBREAK` -> no `EXU_en`, `halted`=1 with `trap`=01, `instret`=2. Later `start` and acks cause no change.
- `tp`=7'h10 -> HALT with `trap`=10. `rst` pulsed 1 cycle -> IDLE, all outputs 0.
- `MEM_TIMEOUT`=4, `imem_ack` never asserted -> `halted`=1 with `trap`=11 after 4 FETCH cycles. In a repeat run, ack on the 4th cycle -> proceeds to DECODE with no trap.
